// File: rtl/l1a_trigger_throttle.sv
// Level-1 accept throttle: turns raw trigger requests into spaced, window-limited l1a pulses,
// tags each accept with an event ID and counts refused requests.
module l1a_trigger_throttle #(
  parameter int MIN_GAP    = 4,
  parameter int WIN_LEN    = 64,
  parameter int MAX_IN_WIN = 8,
  parameter int ID_W       = 24
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            enable_i,
  input  logic                            trig_i,
  input  logic                            busy_i,
  input  logic                            ecr_i,
  output logic                            l1a_o,
  output logic [ID_W-1:0]                 l1a_id_o,
  output logic                            veto_o,
  output logic [15:0]                     drop_cnt_o,
  output logic [$clog2(MAX_IN_WIN+1)-1:0] win_cnt_o
);

  localparam int CW = $clog2(MAX_IN_WIN + 1);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_READY    = 2'd1;
  localparam logic [1:0] ST_HOLDOFF  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [WIN_LEN-1:0] hist_q, hist_d;
  logic [CW-1:0]      win_q, win_d;
  logic [ID_W-1:0]    next_id_q, next_id_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    id_base;
  logic               l1a_q, l1a_d;
  logic [15:0]        drop_q, drop_d;
  logic               ok, acc, drop;

  assign ok   = enable_i & ~busy_i & (state_q == ST_READY) & (win_q < CW'(MAX_IN_WIN));
  assign acc  = trig_i & ok;
  assign drop = trig_i & enable_i & ~acc;

  // The gap counter runs in every state, so a disable/enable toggle cannot shorten the spacing.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = (gap_q > GW'(1)) ? ST_HOLDOFF : ST_READY;
        ST_READY:    if (acc && (MIN_GAP > 1)) state_d = ST_HOLDOFF;
        ST_HOLDOFF:  if (gap_q <= GW'(1)) state_d = ST_READY;
        default:     state_d = ST_DISABLED;
      endcase
    end

    gap_d = gap_q;
    if (acc) begin
      gap_d = GW'(MIN_GAP - 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
  end

  // Window bookkeeping: the newest accept enters and the oldest leaves in the same cycle.
  always_comb begin
    hist_d = {hist_q[WIN_LEN-2:0], acc};
    win_d  = win_q + CW'(acc) - CW'(hist_q[WIN_LEN-1]);
  end

  // An ECR coincident with an accept hands out ID 0 to that accept.
  always_comb begin
    id_base   = ecr_i ? '0 : next_id_q;
    next_id_d = next_id_q;
    id_d      = id_q;
    l1a_d     = acc;
    if (acc) begin
      id_d      = id_base;
      next_id_d = id_base + ID_W'(1);
    end else if (ecr_i) begin
      next_id_d = '0;
    end

    drop_d = drop_q;
    if (ecr_i) begin
      drop_d = {15'd0, drop};
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_DISABLED;
      gap_q     <= '0;
      hist_q    <= '0;
      win_q     <= '0;
      next_id_q <= '0;
      id_q      <= '0;
      l1a_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      hist_q    <= hist_d;
      win_q     <= win_d;
      next_id_q <= next_id_d;
      id_q      <= id_d;
      l1a_q     <= l1a_d;
      drop_q    <= drop_d;
    end
  end

  // Veto is held low while in reset so that every output reads 0 there.
  assign veto_o     = rst_n_i & ~ok;
  assign l1a_o      = l1a_q;
  assign l1a_id_o   = id_q;
  assign drop_cnt_o = drop_q;
  assign win_cnt_o  = win_q;

endmodule

// File: tb/tb_l1a_trigger_throttle.sv
// Randomized and directed bench for l1a_trigger_throttle against a time-stamp based reference model.
module tb_l1a_trigger_throttle;

  localparam int MIN_GAP    = 4;
  localparam int WIN_LEN    = 64;
  localparam int MAX_IN_WIN = 8;

  logic clk = 1'b0;
  logic rst_n_i = 1'b1;
  logic enable_i = 1'b0, trig_i = 1'b0, busy_i = 1'b0, ecr_i = 1'b0;

  logic        l1a_o, veto_o;
  logic [23:0] l1a_id_o;
  logic [15:0] drop_cnt_o;
  logic [3:0]  win_cnt_o;

  logic        l1a_w, veto_w;
  logic [3:0]  id_w;
  logic [15:0] drop_w;
  logic [3:0]  win_w;

  l1a_trigger_throttle #(.MIN_GAP(MIN_GAP), .WIN_LEN(WIN_LEN), .MAX_IN_WIN(MAX_IN_WIN), .ID_W(24)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .enable_i(enable_i), .trig_i(trig_i), .busy_i(busy_i),
    .ecr_i(ecr_i), .l1a_o(l1a_o), .l1a_id_o(l1a_id_o), .veto_o(veto_o),
    .drop_cnt_o(drop_cnt_o), .win_cnt_o(win_cnt_o));

  l1a_trigger_throttle #(.MIN_GAP(MIN_GAP), .WIN_LEN(WIN_LEN), .MAX_IN_WIN(MAX_IN_WIN), .ID_W(4)) dut_w (
    .clk_i(clk), .rst_n_i(rst_n_i), .enable_i(enable_i), .trig_i(trig_i), .busy_i(busy_i),
    .ecr_i(ecr_i), .l1a_o(l1a_w), .l1a_id_o(id_w), .veto_o(veto_w),
    .drop_cnt_o(drop_w), .win_cnt_o(win_w));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: accept time stamps, last accept time and whether enable was seen last edge.
  int          cyc;
  bit          en_prev;
  int          last_acc;
  int          acc_q[$];
  int          m_next_id;
  int          m_drop;
  bit          m_acc;
  bit          exp_l1a, exp_veto, obs_veto;
  logic [23:0] exp_id;
  logic [3:0]  exp_win;

  function automatic int win_count(input int t);
    int n = 0;
    foreach (acc_q[k]) if (acc_q[k] >= t - WIN_LEN && acc_q[k] <= t - 1) n++;
    return n;
  endfunction

  task automatic model_reset();
    cyc = 0; en_prev = 0; last_acc = -1000000; acc_q.delete();
    m_next_id = 0; m_drop = 0; exp_l1a = 0; exp_id = '0; exp_win = '0;
  endtask

  task automatic tick();
    bit ok;
    int idv;
    #2;
    ok = enable_i && !busy_i && en_prev && (cyc - last_acc >= MIN_GAP) &&
         (win_count(cyc) < MAX_IN_WIN);
    exp_veto = !ok;
    obs_veto = veto_o;
    m_acc = trig_i && ok;
    @(posedge clk);
    exp_l1a = m_acc;
    if (m_acc) begin
      idv = ecr_i ? 0 : m_next_id;
      exp_id = 24'(idv);
      m_next_id = (idv + 1) % (1 << 24);
      acc_q.push_back(cyc);
      last_acc = cyc;
    end else if (ecr_i) begin
      m_next_id = 0;
    end
    if (ecr_i) m_drop = (trig_i && enable_i && !m_acc) ? 1 : 0;
    else if (trig_i && enable_i && !m_acc && m_drop < 65535) m_drop++;
    en_prev = enable_i;
    cyc++;
    while (acc_q.size() > 0 && acc_q[0] < cyc - WIN_LEN) acc_q.delete(0);
    exp_win = 4'(win_count(cyc));
    #1;
  endtask

  task automatic idle(input int n);
    trig_i = 1'b0; ecr_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    #1 rst_n_i = 1'b0;
    #1;
    n_cmp++; if (l1a_o !== 1'b0) begin n_bad++; $display("FAIL reset_l1a got=%b want=0", l1a_o); end
    n_cmp++; if (l1a_id_o !== 24'd0) begin n_bad++; $display("FAIL reset_id got=%0d want=0", l1a_id_o); end
    n_cmp++; if (veto_o !== 1'b0) begin n_bad++; $display("FAIL reset_veto got=%b want=0", veto_o); end
    n_cmp++; if (drop_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt_o); end
    n_cmp++; if (win_cnt_o !== 4'd0) begin n_bad++; $display("FAIL reset_win got=%0d want=0", win_cnt_o); end
    @(posedge clk); #1;
    rst_n_i = 1'b1; enable_i = 1'b1; busy_i = 1'b0;
    model_reset();
    tick();
    n_cmp++; if (obs_veto !== 1'b1) begin n_bad++; $display("FAIL veto_disabled got=%b want=1", obs_veto); end
  endtask

  task automatic test_spacing();
    int n_l1a = 0;
    idle(70);
    for (int i = 0; i < 10; i++) begin
      trig_i = (i == 0 || i == 3 || i == 4);
      tick();
      n_cmp++; if (l1a_o !== exp_l1a) begin n_bad++; $display("FAIL spacing_l1a i=%0d got=%b want=%b", i, l1a_o, exp_l1a); end
      if (l1a_o === 1'b1) n_l1a++;
    end
    n_cmp++; if (n_l1a != 2) begin n_bad++; $display("FAIL spacing_count got=%0d want=2", n_l1a); end
    n_cmp++; if (drop_cnt_o !== 16'd1) begin n_bad++; $display("FAIL spacing_drop got=%0d want=1", drop_cnt_o); end
  endtask

  task automatic test_window();
    int seen[$];
    int n_first = 0;
    int inwin;
    idle(70);
    trig_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (l1a_o === 1'b1) begin
        seen.push_back(i);
        if (i < 29) n_first++;
      end
      inwin = 0;
      foreach (seen[k]) if (seen[k] > i - WIN_LEN) inwin++;
      n_cmp++; if (l1a_o !== exp_l1a) begin n_bad++; $display("FAIL window_l1a i=%0d got=%b want=%b", i, l1a_o, exp_l1a); end
      n_cmp++; if (win_cnt_o !== exp_win) begin n_bad++; $display("FAIL window_cnt i=%0d got=%0d want=%0d", i, win_cnt_o, exp_win); end
      n_cmp++; if (win_cnt_o > 4'd8 || inwin > MAX_IN_WIN) begin n_bad++; $display("FAIL window_limit i=%0d win=%0d inwin=%0d max=8", i, win_cnt_o, inwin); end
    end
    n_cmp++; if (n_first != 8) begin n_bad++; $display("FAIL window_first29 got=%0d want=8", n_first); end
    trig_i = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable_i = ($urandom % 20) != 0;
      trig_i   = ($urandom % 3) == 0;
      busy_i   = ($urandom % 8) == 0;
      ecr_i    = ($urandom % 100) == 0;
      tick();
      n_cmp++; if (obs_veto !== exp_veto) begin n_bad++; $display("FAIL rand_veto i=%0d got=%b want=%b", i, obs_veto, exp_veto); end
      n_cmp++; if (l1a_o !== exp_l1a) begin n_bad++; $display("FAIL rand_l1a i=%0d got=%b want=%b", i, l1a_o, exp_l1a); end
      n_cmp++; if (l1a_id_o !== exp_id) begin n_bad++; $display("FAIL rand_id i=%0d got=%0d want=%0d", i, l1a_id_o, exp_id); end
      n_cmp++; if (drop_cnt_o !== 16'(m_drop)) begin n_bad++; $display("FAIL rand_drop i=%0d got=%0d want=%0d", i, drop_cnt_o, m_drop); end
      n_cmp++; if (win_cnt_o !== exp_win) begin n_bad++; $display("FAIL rand_win i=%0d got=%0d want=%0d", i, win_cnt_o, exp_win); end
    end
    enable_i = 1'b1; busy_i = 1'b0; trig_i = 1'b0; ecr_i = 1'b0;
  endtask

  task automatic test_busy();
    int d0;
    int n_l1a = 0;
    idle(5);
    d0 = int'(drop_cnt_o);
    busy_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      trig_i = (i % 2 == 0);
      tick();
      n_cmp++; if (obs_veto !== 1'b1) begin n_bad++; $display("FAIL busy_veto i=%0d got=%b want=1", i, obs_veto); end
      n_cmp++; if (l1a_o !== 1'b0) begin n_bad++; $display("FAIL busy_l1a i=%0d got=%b want=0", i, l1a_o); end
    end
    n_cmp++; if (drop_cnt_o !== 16'(d0 + 10)) begin n_bad++; $display("FAIL busy_drop got=%0d want=%0d", drop_cnt_o, d0 + 10); end
    trig_i = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (l1a_o !== 1'b0) n_l1a++;
    end
    n_cmp++; if (n_l1a != 0) begin n_bad++; $display("FAIL sat_l1a got=%0d want=0", n_l1a); end
    n_cmp++; if (drop_cnt_o !== 16'hFFFF) begin n_bad++; $display("FAIL sat_drop got=%h want=ffff", drop_cnt_o); end
    trig_i = 1'b0; busy_i = 1'b0;
  endtask

  task automatic test_ecr();
    idle(70);
    for (int e = 0; e < 5; e++) begin
      trig_i = 1'b1; tick();
      n_cmp++; if (l1a_o !== exp_l1a || l1a_id_o !== exp_id) begin n_bad++; $display("FAIL ecr_pre e=%0d got=%b/%0d want=%b/%0d", e, l1a_o, l1a_id_o, exp_l1a, exp_id); end
      idle(4);
    end
    trig_i = 1'b1; ecr_i = 1'b1; tick();
    n_cmp++; if (l1a_o !== 1'b1) begin n_bad++; $display("FAIL ecr_l1a got=%b want=1", l1a_o); end
    n_cmp++; if (l1a_id_o !== 24'd0) begin n_bad++; $display("FAIL ecr_id got=%0d want=0", l1a_id_o); end
    n_cmp++; if (drop_cnt_o !== 16'd0) begin n_bad++; $display("FAIL ecr_drop got=%0d want=0", drop_cnt_o); end
    idle(4);
    trig_i = 1'b1; tick();
    n_cmp++; if (l1a_o !== 1'b1 || l1a_id_o !== 24'd1) begin n_bad++; $display("FAIL ecr_next got=%b/%0d want=1/1", l1a_o, l1a_id_o); end
    trig_i = 1'b0;
  endtask

  task automatic test_id_wrap();
    logic [3:0] kk;
    idle(70);
    ecr_i = 1'b1; tick(); ecr_i = 1'b0;
    idle(8);
    for (int k = 0; k < 17; k++) begin
      kk = 4'(k % 16);
      trig_i = 1'b1; tick();
      n_cmp++; if (l1a_w !== 1'b1 || id_w !== kk) begin n_bad++; $display("FAIL wrap_id4 k=%0d got=%b/%0d want=1/%0d", k, l1a_w, id_w, kk); end
      n_cmp++; if (l1a_id_o !== 24'(k)) begin n_bad++; $display("FAIL wrap_id24 k=%0d got=%0d want=%0d", k, l1a_id_o, k); end
      idle(8);
    end
  endtask

  task automatic test_reset_mid();
    idle(70);
    trig_i = 1'b1; tick();
    n_cmp++; if (l1a_o !== 1'b1) begin n_bad++; $display("FAIL mid_pre_l1a got=%b want=1", l1a_o); end
    #2 rst_n_i = 1'b0;
    #1;
    n_cmp++; if (l1a_o !== 1'b0 || l1a_w !== 1'b0) begin n_bad++; $display("FAIL mid_l1a got=%b want=0", l1a_o); end
    n_cmp++; if (l1a_id_o !== 24'd0) begin n_bad++; $display("FAIL mid_id got=%0d want=0", l1a_id_o); end
    n_cmp++; if (drop_cnt_o !== 16'd0 || win_cnt_o !== 4'd0) begin n_bad++; $display("FAIL mid_cnt got=%0d/%0d want=0/0", drop_cnt_o, win_cnt_o); end
    n_cmp++; if (veto_o !== 1'b0) begin n_bad++; $display("FAIL mid_veto got=%b want=0", veto_o); end
    @(posedge clk); @(posedge clk); #1;
    rst_n_i = 1'b1;
    model_reset();
    tick();
    n_cmp++; if (l1a_o !== 1'b0 || exp_l1a !== 1'b0) begin n_bad++; $display("FAIL mid_first got=%b want=0", l1a_o); end
    tick();
    n_cmp++; if (l1a_o !== 1'b1 || l1a_id_o !== 24'd0) begin n_bad++; $display("FAIL mid_second got=%b/%0d want=1/0", l1a_o, l1a_id_o); end
    n_cmp++; if (drop_cnt_o !== 16'(m_drop)) begin n_bad++; $display("FAIL mid_drop got=%0d want=%0d", drop_cnt_o, m_drop); end
    trig_i = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_spacing();
    test_window();
    test_random();
    test_busy();
    test_ecr();
    test_id_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
